// File: rtl/booth4_controller_if.sv
// ---------------------------------------------------------------------------
// booth4_controller_if
// Handshake bundle between the radix-4 Booth multiplier controller and the
// host that supplies operand bytes and consumes product words.
//   start    : host -> ctrl, begin a multiply (sampled only when idle)
//   inValid  : host -> ctrl, an operand byte is present on the datapath inBus
//   inReady  : ctrl -> host, the byte on inBus is taken this cycle
//   outValid : ctrl -> host, datapath outBus holds a product word
//   outReady : host -> ctrl, the product word is taken this cycle
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface booth4_controller_if;
    logic start;
    logic inValid;
    logic inReady;
    logic outValid;
    logic outReady;

    modport master (
        output start,
        output inValid,
        output outReady,
        input  inReady,
        input  outValid
    );

    modport slave (
        input  start,
        input  inValid,
        input  outReady,
        output inReady,
        output outValid
    );
endinterface

// File: rtl/booth4_controller.sv
// ---------------------------------------------------------------------------
// booth4_controller
// Control FSM for a radix-4 Booth multiplier datapath. Loads two N-bit
// operands as four bytes (A low, A high, X low, X high), runs N/2 iterations
// of add/subtract + two arithmetic right shifts of {P,X}, then presents the
// high and low product words.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   hs             : handshake bundle (start, inValid/inReady, outValid/outReady)
//   lsb3           : low three bits of X from the datapath (Booth digit)
//   overflow       : overflow flag of the last datapath add
//   busy           : high in every state except IDLE
//   ovf            : sticky overflow for the current / most recent multiply
//   lmA..ldOv,
//   coefSel        : datapath control strobes
// ---------------------------------------------------------------------------
module booth4_controller #(
    parameter int N = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    booth4_controller_if.slave        hs,
    input  logic [2:0]                lsb3,
    input  logic                      overflow,
    output logic                      busy,
    output logic                      ovf,
    output logic                      lmA,
    output logic                      lmX,
    output logic                      ldA,
    output logic                      ldX,
    output logic                      ldP,
    output logic                      shX,
    output logic                      shP,
    output logic                      clrP,
    output logic                      sub,
    output logic                      putOut,
    output logic                      shSignExtend,
    output logic                      ldCo,
    output logic                      ldOv,
    output logic [1:0]                coefSel
);

    localparam int HALF = N / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    typedef enum logic [3:0] {
        IDLE, LD_AL, LD_AH, LD_XL, LD_XH, ADD, SH1, SH2, OUT_HI, OUT_LO
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic            ovf_reg, ovf_next;

    // State register, iteration counter and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        cnt_inc    = cnt_reg + CW'(1);
        case (state_reg)
            IDLE: begin
                if (hs.start) begin
                    state_next = LD_AL;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            LD_AL:  if (hs.inValid) state_next = LD_AH;
            LD_AH:  if (hs.inValid) state_next = LD_XL;
            LD_XL:  if (hs.inValid) state_next = LD_XH;
            LD_XH:  if (hs.inValid) state_next = ADD;
            ADD:    state_next = SH1;
            SH1: begin
                // datapath overflow flag was captured on the ADD edge
                ovf_next   = ovf_reg | overflow;
                state_next = SH2;
            end
            SH2: begin
                cnt_next   = cnt_inc;
                state_next = (cnt_inc < HALF_C) ? ADD : OUT_HI;
            end
            OUT_HI: if (hs.outReady) state_next = OUT_LO;
            OUT_LO: if (hs.outReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state_reg != IDLE);
        ovf          = ovf_reg;
        hs.inReady   = 1'b0;
        hs.outValid  = 1'b0;
        lmA          = 1'b0;
        lmX          = 1'b0;
        ldA          = 1'b0;
        ldX          = 1'b0;
        ldP          = 1'b0;
        shX          = 1'b0;
        shP          = 1'b0;
        clrP         = 1'b0;
        sub          = 1'b0;
        putOut       = 1'b0;
        shSignExtend = 1'b0;
        ldCo         = 1'b0;
        ldOv         = 1'b0;
        coefSel      = 2'b00;
        case (state_reg)
            LD_AL: begin
                hs.inReady = 1'b1;
                ldA        = hs.inValid;
                clrP       = 1'b1;
            end
            LD_AH: begin
                hs.inReady = 1'b1;
                ldA        = hs.inValid;
                lmA        = 1'b1;
            end
            LD_XL: begin
                hs.inReady = 1'b1;
                ldX        = hs.inValid;
            end
            LD_XH: begin
                hs.inReady = 1'b1;
                ldX        = hs.inValid;
                lmX        = 1'b1;
            end
            ADD: begin
                ldP  = 1'b1;
                ldCo = 1'b1;
                ldOv = 1'b1;
                // Booth digit: coefSel picks the multiple, sub negates it
                case (lsb3)
                    3'b001: coefSel = 2'b01;
                    3'b010: coefSel = 2'b10;
                    3'b011: coefSel = 2'b11;
                    3'b100: begin coefSel = 2'b11; sub = 1'b1; end
                    3'b101: begin coefSel = 2'b10; sub = 1'b1; end
                    3'b110: begin coefSel = 2'b01; sub = 1'b1; end
                    default: coefSel = 2'b00;
                endcase
            end
            SH1, SH2: begin
                shP          = 1'b1;
                shX          = 1'b1;
                shSignExtend = 1'b1;
            end
            OUT_HI: hs.outValid = 1'b1;
            OUT_LO: begin
                hs.outValid = 1'b1;
                putOut      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth4_controller.sv
// ---------------------------------------------------------------------------
// tb_booth4_controller
// Drives the controller together with a small behavioural Booth datapath and
// checks handshake timing, control invariants, latency, product words and
// the sticky overflow flag against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_booth4_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth4_controller_if bus ();

    logic [2:0]  lsb3;
    logic        overflow;
    logic        busy, ovf;
    logic        lmA, lmX, ldA, ldX, ldP, shX, shP, clrP, sub, putOut;
    logic        shSignExtend, ldCo, ldOv;
    logic [1:0]  coefSel;

    logic [7:0]  in_bus;
    logic [15:0] out_bus;

    booth4_controller #(.N(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs           (bus),
        .lsb3         (lsb3),
        .overflow     (overflow),
        .busy         (busy),
        .ovf          (ovf),
        .lmA          (lmA),
        .lmX          (lmX),
        .ldA          (ldA),
        .ldX          (ldX),
        .ldP          (ldP),
        .shX          (shX),
        .shP          (shP),
        .clrP         (clrP),
        .sub          (sub),
        .putOut       (putOut),
        .shSignExtend (shSignExtend),
        .ldCo         (ldCo),
        .ldOv         (ldOv),
        .coefSel      (coefSel)
    );

    // ---------------- behavioural datapath (P and X are N+1 bits) ----------
    logic [15:0] a_dp;
    logic [16:0] p_dp, x_dp;
    logic        ov_dp;

    assign lsb3     = x_dp[2:0];
    assign overflow = ov_dp;
    assign out_bus  = putOut ? x_dp[16:1] : p_dp[15:0];

    // returns {overflow, new P}
    function automatic logic [17:0] dp_add(input logic [16:0] p, input logic [15:0] a,
                                           input logic [1:0] sel, input logic sb);
        logic signed [17:0] mag, sum;
        mag = {{2{a[15]}}, a};
        if (sel == 2'b11) mag = mag <<< 1;
        if (sel == 2'b00) mag = '0;
        sum = {p[16], p} + (sb ? -mag : mag);
        return {sum[17] ^ sum[16], sum[16:0]};
    endfunction

    always @(posedge clk) begin
        if (ldA) begin
            if (lmA) a_dp[15:8] <= in_bus;
            else     a_dp[7:0]  <= in_bus;
        end
        if (ldX) begin
            if (lmX) x_dp[16:9] <= in_bus;
            else     x_dp[8:0]  <= {in_bus, 1'b0};
        end
        if (clrP) p_dp <= '0;
        if (ldP)  p_dp <= dp_add(p_dp, a_dp, coefSel, sub)[16:0];
        if (ldOv) ov_dp <= dp_add(p_dp, a_dp, coefSel, sub)[17];
        if (shP)  {p_dp, x_dp} <= {p_dp[16], p_dp, x_dp[16:1]};
    end

    // ---------------- reference: product and Booth-recurrence overflow -----
    task automatic ref_mul(input logic [15:0] a, input logic [15:0] x,
                           output logic [15:0] hi, output logic [15:0] lo,
                           output logic ov);
        longint      prod, acc, as;
        logic [16:0] xe;
        logic [2:0]  bits;
        int          d;
        as   = longint'($signed(a));
        prod = as * longint'($signed(x));
        hi   = prod[31:16];
        lo   = prod[15:0];
        xe   = {x, 1'b0};
        acc  = 0;
        ov   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits = xe[2*i +: 3];
            d    = -2 * int'(bits[2]) + int'(bits[1]) + int'(bits[0]);
            acc  = acc + longint'(d) * as;
            if (acc > 65535 || acc < -65536) ov = 1'b1;
            acc  = acc >>> 2;
        end
    endtask

    // ---------------- checking ---------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    wire [16:0] all_out = {lmA, lmX, ldA, ldX, ldP, shX, shP, clrP, sub, putOut,
                           shSignExtend, ldCo, ldOv, coefSel, bus.inReady, bus.outValid};

    // One multiply; called at a negedge with the controller idle.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] x,
                          input int in_stall, input int out_stall);
        logic [7:0]  bytes [4];
        logic [15:0] ehi, elo, ghi, glo;
        logic        eov;
        int          cyc;
        bytes[0] = a[7:0];
        bytes[1] = a[15:8];
        bytes[2] = x[7:0];
        bytes[3] = x[15:8];
        ref_mul(a, x, ehi, elo, eov);

        chk("idle_busy", busy, 0);
        bus.start    = 1'b1;
        bus.inValid  = 1'b1;
        bus.outReady = 1'b1;
        @(negedge clk);
        bus.start = 1'($urandom_range(0, 1));
        cyc = 0;
        chk("start_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            chk("in_ready", bus.inReady, 1);
            if (k == 1) begin
                for (int s = 0; s < in_stall; s++) begin
                    bus.inValid = 1'b0;
                    @(negedge clk);
                    cyc++;
                    bus.start = 1'($urandom_range(0, 1));
                    chk("ld_stall_hold", {bus.inReady, lmA, ldA, clrP, busy}, 5'b11001);
                end
            end
            bus.inValid = 1'b1;
            in_bus      = bytes[k];
            @(negedge clk);
            cyc++;
        end
        while (!bus.outValid && cyc < 200) begin
            chk("clr_excl", clrP & (ldP | shP), 0);
            chk("sh_ctl", shP & ~(shX & shSignExtend), 0);
            chk("add_ctl", (ldP ^ ldCo) | (ldP ^ ldOv), 0);
            bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("latency", cyc, 28 + in_stall);
        chk("ovf_out_hi", ovf, eov);
        chk("put_hi", putOut, 0);
        ghi = out_bus;
        for (int s = 0; s < out_stall; s++) begin
            bus.outReady = 1'b0;
            @(negedge clk);
            chk("out_stall_hold", {bus.outValid, putOut, busy}, 3'b101);
        end
        bus.outReady = 1'b1;
        @(negedge clk);
        chk("put_lo", {bus.outValid, putOut}, 2'b11);
        glo = out_bus;
        bus.start = 1'b1;       // coincides with OUT_LO acceptance: must be ignored
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_idle", {busy, bus.outValid, bus.inReady}, 0);
        chk("ovf_hold", ovf, eov);
        if (!eov) begin
            chk("word_hi", ghi, ehi);
            chk("word_lo", glo, elo);
        end
        $display("mul a=%h x=%h stall=%0d/%0d -> hi=%h lo=%h ovf=%0d (ref %h %h %0d)",
                 a, x, in_stall, out_stall, ghi, glo, ovf, ehi, elo, eov);
    endtask

    // Start a multiply and hit reset cyc_target edges after the start edge.
    task automatic reset_mid(input int cyc_target);
        bus.start   = 1'b1;
        bus.inValid = 1'b1;
        in_bus      = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (cyc_target) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_outputs", {all_out, busy, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset after %0d edges -> busy=%0d outs=%h", cyc_target, busy, all_out);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        in_bus       = '0;
        #1;
        chk("reset_state", {all_out, busy, ovf}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_mul(16'h0003, 16'h0005, 0, 0);
        do_mul(16'hFFFE, 16'h0007, 0, 0);
        do_mul(16'h7FFF, 16'h7FFF, 0, 0);
        do_mul(16'h8000, 16'h8000, 0, 0);
        chk("ovf_8000", ovf, 1);
        rst = 1'b1;
        #1;
        chk("rst_clears_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        do_mul(16'h0003, 16'h0005, 3, 2);

        reset_mid(11);          // SH1 of the third iteration
        do_mul(16'h0003, 16'h0005, 0, 0);
        reset_mid(1);           // mid-load
        do_mul(16'h8001, 16'h7FFF, 1, 0);
        reset_mid(28);          // OUT_HI
        do_mul(16'h0000, 16'hFFFF, 0, 1);

        for (int i = 0; i < 20; i++) begin
            do_mul(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/booth4_controller.md
BOOTH4_CONTROLLER -- requirements
Module: booth4_controller

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning operand width; N SHALL be even and at least 4, and the iteration count SHALL be N/2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes SHALL occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; it SHALL be sampled only in IDLE.
REQ-005 The block SHALL have ports inValid (input, 1 bit: a byte is present on the datapath inBus) and inReady (output, 1 bit: the controller accepts that byte this cycle).
REQ-006 The block SHALL have ports outValid (output, 1 bit: datapath outBus holds a product word) and outReady (input, 1 bit: the consumer accepts that word).
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port ovf, output, 1 bit: sticky overflow flag for the current or most recent multiply.
REQ-009 The block SHALL have ports lsb3 (input, 3 bits) and overflow (input, 1 bit), both driven from the datapath.
REQ-010 The block SHALL drive outputs lmA, lmX, ldA, ldX, ldP, shX, shP, clrP, sub, putOut, shSignExtend, ldCo and ldOv, each 1 bit, plus coefSel (2 bits), straight to the same-named datapath inputs.

Function
REQ-011 The FSM SHALL use the states IDLE, LD_AL, LD_AH, LD_XL, LD_XH, ADD, SH1, SH2, OUT_HI and OUT_LO, plus an iteration counter of width clog2(N/2)+1.
REQ-012 IDLE SHALL go to LD_AL when start=1, and SHALL clear ovf and the counter on that edge.
REQ-013 Each LD_* state SHALL assert inReady and SHALL advance only on an edge where inValid=1; inValid=0 SHALL hold the state with ldA=ldX=0.
REQ-014 LD_AL SHALL drive ldA=inValid, lmA=0 and clrP=1; LD_AH SHALL drive ldA=inValid and lmA=1.
REQ-015 LD_XL SHALL drive ldX=inValid and lmX=0; LD_XH SHALL drive ldX=inValid and lmX=1.
REQ-016 The load byte order SHALL be A low, A high, X low, X high; LD_XH SHALL go to ADD on acceptance.
REQ-017 ADD SHALL drive ldP=ldCo=ldOv=1 with coefSel and sub decoded combinationally from lsb3.
REQ-018 The lsb3 decode SHALL be: 000 or 111 -> coefSel=00, sub=0; 001 -> 01/0; 010 -> 10/0; 011 -> 11/0; 100 -> 11/1; 101 -> 10/1; 110 -> 01/1.
REQ-019 ADD SHALL always go to SH1.
REQ-020 SH1 and SH2 SHALL each drive shP=shX=1 and shSignExtend=1, giving an arithmetic right shift of {P,X} by one bit per cycle.
REQ-021 SH1 SHALL OR the overflow input into ovf, then go to SH2.
REQ-022 SH2 SHALL increment the counter and SHALL go to ADD if the incremented count is less than N/2, else to OUT_HI.
REQ-023 OUT_HI SHALL drive outValid=1 and putOut=0 (high word on outBus), and SHALL go to OUT_LO on an edge with outReady=1.
REQ-024 OUT_LO SHALL drive outValid=1 and putOut=1 (low word, X[N:1]), and SHALL go to IDLE on an edge with outReady=1.
REQ-025 Every datapath control not listed for a state SHALL be 0 in that state.
REQ-026 clrP SHALL never be asserted together with ldP or shP.
REQ-027 Latency SHALL be: with inValid held at 1, OUT_HI is entered exactly 4+3*(N/2) edges after the edge that samples start (28 for N=16).
REQ-028 start asserted outside IDLE SHALL be ignored.
REQ-029 start arriving on the same edge as the OUT_LO acceptance SHALL be ignored; a new start must be seen in IDLE.
REQ-030 ovf SHALL hold its value through IDLE until the next accepted start.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, counter 0 and ovf 0, with every output low, regardless of the current state, including mid-load, mid-iteration and output states.
REQ-032 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-033 A=3, X=5, inValid held at 1, outReady held at 1: outValid rises 28 cycles after start; words are 0x0000 then 0x000F; ovf=0.
REQ-034 A=-2 (0xFFFE), X=7: words are 0xFFFF then 0xFFF2; ovf=0.
REQ-035 A=X=0x7FFF: words are 0x3FFF then 0x0001; ovf=0.
REQ-036 A=X=0x8000: ovf=1 at OUT_HI, because the final -2A step overflows.
REQ-037 inValid low for 3 cycles in LD_AH, and outReady low for 2 cycles in OUT_HI: the state and inReady/outValid hold during each stall; the final result is unchanged versus the no-stall run.
REQ-038 rst pulsed during SH1 of iteration 3, then a fresh multiply 3x5 is run: busy=0 and all outputs low immediately on reset, and the new result is correct (0x0000, 0x000F).
